sccb_cfg_seq: RTL and testbench
===============================

SCCB_CFG_SEQ -- requirements
Module: sccb_cfg_seq

Interface
REQ-001 Parameter START_INDEX, default 2: first LUT index issued.
REQ-002 Parameter LAST_INDEX, default 166: last LUT index issued (inclusive).
REQ-003 Parameter POR_CYCLES, default 1024: power-up wait before the first fetch.
REQ-004 Parameter DELAY_CYCLES, default 4096: settle wait after a delay entry or a sensor soft reset.
REQ-005 Parameter MAX_RETRY, default 3: re-issues allowed per entry after a NACK.
REQ-006 iCLK  in  1  single clock; all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 cfg_start  in  1  one-cycle pulse; restarts the sequence from DONE or ERROR only.
REQ-009 LUT_INDEX  out  8  current LUT address.
REQ-010 LUT_DATA  in  16  {reg[15:8], data[7:0]}; combinational response to LUT_INDEX.
REQ-011 Slave_Addr  in  8  8-bit device write address (e.g. 8'h42).
REQ-012 wr_req  out  1  one-cycle pulse requesting one 3-byte write from the I2C engine.
REQ-013 wr_addr, wr_reg, wr_data  out  8 each  transaction bytes.
REQ-014 wr_busy  in  1  I2C engine is executing a transaction.
REQ-015 wr_done  in  1  one-cycle pulse at transaction end.
REQ-016 wr_nack  in  1  NACK seen; valid only while wr_done=1.
REQ-017 cfg_done  out  1  all entries written.
REQ-018 cfg_err  out  1  retries exhausted.
REQ-019 err_index  out  8  LUT_INDEX of the failing entry.

Function
REQ-020 States: POR, FETCH, ISSUE, WAIT, SETTLE, NEXT, DONE, ERROR.
REQ-021 POR: count POR_CYCLES, then go to FETCH with LUT_INDEX=START_INDEX.
REQ-022 FETCH, end marker: LUT_DATA=16'hFFFF goes to DONE.
REQ-023 FETCH, delay entry: LUT_DATA=16'hFFF0 goes to SETTLE; no write is issued.
REQ-024 FETCH, any other value: register the three bytes (wr_addr=Slave_Addr, wr_reg=LUT_DATA[15:8], wr_data=LUT_DATA[7:0]) and go to ISSUE.
REQ-025 ISSUE: while wr_busy=1, hold; once wr_busy=0, pulse wr_req for exactly one cycle and go to WAIT.
REQ-026 wr_addr, wr_reg and wr_data remain stable from ISSUE entry until the wr_done that ends the transaction.
REQ-027 WAIT, wr_done=1 and wr_nack=0: clear the retry count. If the entry was 8'h12 with data bit 7 = 1, go to SETTLE; otherwise go to NEXT.
REQ-028 WAIT, wr_done=1 and wr_nack=1, retry count < MAX_RETRY: increment the retry count and re-enter ISSUE with the same bytes.
REQ-029 WAIT, wr_done=1 and wr_nack=1, retry count = MAX_RETRY: latch err_index=LUT_INDEX and go to ERROR.
REQ-030 wr_nack is ignored whenever wr_done=0.
REQ-031 SETTLE: count DELAY_CYCLES, then go to NEXT.
REQ-032 NEXT: if LUT_INDEX=LAST_INDEX, go to DONE; otherwise increment LUT_INDEX and go to FETCH.
REQ-033 LUT_INDEX never wraps past 8'hFF.
REQ-034 DONE: cfg_done=1, held until reset or cfg_start.
REQ-035 ERROR: cfg_err=1, held until reset or cfg_start.
REQ-036 cfg_start in DONE or ERROR: clear cfg_done, cfg_err and the retry count, set LUT_INDEX=START_INDEX, go to FETCH (the POR wait is skipped).
REQ-037 cfg_start in any other state is ignored.
REQ-038 Counters are sized to hold max(POR_CYCLES, DELAY_CYCLES) without overflow.
REQ-039 Only one wr_req is outstanding at a time; a wr_done received outside WAIT is ignored.

Reset
REQ-040 Asserting rst in any state, including mid-transaction, forces state POR.
REQ-041 Output values under reset: LUT_INDEX=START_INDEX, wr_req=0, wr_addr/wr_reg/wr_data=0, cfg_done=0, cfg_err=0, err_index=0; counters are cleared.
REQ-042 After rst deasserts, the POR wait runs in full before the first fetch.

Verification
REQ-043 Normal ACK: LUT = {2:16'h1214, 3:16'h40d0, 4:16'hFFFF}, every transaction ACKed -> exactly two wr_req pulses carrying (42,12,14) then (42,40,d0), then cfg_done=1 with LUT_INDEX=4.
REQ-044 Soft reset entry: 2:16'h1280 -> after its wr_done, at least DELAY_CYCLES cycles pass before LUT_INDEX becomes 3.
REQ-045 Retry limit: every transaction on index 5 NACKs -> 4 wr_req pulses for that entry, then cfg_err=1 and err_index=5, and no further wr_req.
REQ-046 Busy engine: wr_busy=1 held 20 cycles on entry to ISSUE -> wr_req fires on the first cycle after wr_busy falls, with bytes unchanged.
REQ-047 Reset mid-sequence: rst pulsed while in WAIT at index 50 -> outputs take their reset values immediately; the sequence then restarts at index 2 after POR_CYCLES.
REQ-048 Restart: cfg_start pulse in DONE -> cfg_done=0 next cycle and the full sequence reruns from START_INDEX with no POR wait.

Source files
------------

// File: rtl/sccb_cfg_seq.sv
// Sensor configuration sequencer: walks a register LUT and hands 3-byte SCCB
// writes to an external I2C engine, with NACK retry, delay entries and settle waits.
module sccb_cfg_seq #(
  parameter int START_INDEX  = 2,
  parameter int LAST_INDEX   = 166,
  parameter int POR_CYCLES   = 1024,
  parameter int DELAY_CYCLES = 4096,
  parameter int MAX_RETRY    = 3
) (
  input  logic        iCLK,
  input  logic        rst,
  input  logic        cfg_start,
  output logic [7:0]  LUT_INDEX,
  input  logic [15:0] LUT_DATA,
  input  logic [7:0]  Slave_Addr,
  output logic        wr_req,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_reg,
  output logic [7:0]  wr_data,
  input  logic        wr_busy,
  input  logic        wr_done,
  input  logic        wr_nack,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [7:0]  err_index
);

  // state  | meaning
  // POR    | power-up wait before the first fetch
  // FETCH  | decode LUT_DATA at LUT_INDEX
  // ISSUE  | wait for an idle engine, then pulse wr_req
  // WAIT   | wait for wr_done; ACK advances, NACK retries or fails
  // SETTLE | fixed wait after a delay entry or sensor soft reset
  // NEXT   | advance LUT_INDEX or finish at LAST_INDEX
  // DONE   | all entries written
  // ERROR  | retries exhausted on err_index
  typedef enum logic [2:0] {
    S_POR, S_FETCH, S_ISSUE, S_WAIT, S_SETTLE, S_NEXT, S_DONE, S_ERROR
  } state_t;

  localparam int CNT_MAX = (POR_CYCLES > DELAY_CYCLES) ? POR_CYCLES : DELAY_CYCLES;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam int RW      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] POR_LAST   = CW'((POR_CYCLES > 0) ? POR_CYCLES - 1 : 0);
  localparam logic [CW-1:0] DLY_LAST   = CW'((DELAY_CYCLES > 0) ? DELAY_CYCLES - 1 : 0);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [7:0]    IDX_START  = 8'(START_INDEX);
  localparam logic [7:0]    IDX_LAST   = 8'(LAST_INDEX);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retry;

  always_ff @(posedge iCLK or posedge rst) begin
    if (rst) begin
      state     <= S_POR;
      cnt       <= '0;
      retry     <= '0;
      LUT_INDEX <= IDX_START;
      wr_req    <= 1'b0;
      wr_addr   <= 8'h00;
      wr_reg    <= 8'h00;
      wr_data   <= 8'h00;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      err_index <= 8'h00;
    end else begin
      wr_req <= 1'b0;
      case (state)
        S_POR: begin
          if (cnt == POR_LAST) begin
            cnt       <= '0;
            LUT_INDEX <= IDX_START;
            state     <= S_FETCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FETCH: begin
          if (LUT_DATA == 16'hFFFF) begin
            cfg_done <= 1'b1;
            state    <= S_DONE;
          end else if (LUT_DATA == 16'hFFF0) begin
            cnt   <= '0;
            state <= S_SETTLE;
          end else begin
            wr_addr <= Slave_Addr;
            wr_reg  <= LUT_DATA[15:8];
            wr_data <= LUT_DATA[7:0];
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!wr_busy) begin
            wr_req <= 1'b1;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // wr_nack only has meaning alongside wr_done
          if (wr_done) begin
            if (!wr_nack) begin
              retry <= '0;
              if (wr_reg == 8'h12 && wr_data[7]) begin
                cnt   <= '0;
                state <= S_SETTLE;
              end else begin
                state <= S_NEXT;
              end
            end else if (retry < RETRY_MAX) begin
              retry <= retry + 1'b1;
              state <= S_ISSUE;
            end else begin
              err_index <= LUT_INDEX;
              cfg_err   <= 1'b1;
              state     <= S_ERROR;
            end
          end
        end
        S_SETTLE: begin
          if (cnt == DLY_LAST) begin
            cnt   <= '0;
            state <= S_NEXT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_NEXT: begin
          // stopping at 8'hFF as well keeps the index from wrapping
          if (LUT_INDEX == IDX_LAST || LUT_INDEX == 8'hFF) begin
            cfg_done <= 1'b1;
            state    <= S_DONE;
          end else begin
            LUT_INDEX <= LUT_INDEX + 1'b1;
            state     <= S_FETCH;
          end
        end
        S_DONE, S_ERROR: begin
          if (cfg_start) begin
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            retry     <= '0;
            LUT_INDEX <= IDX_START;
            state     <= S_FETCH;
          end
        end
        default: state <= S_POR;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_cfg_seq.sv
// Bench for sccb_cfg_seq: a randomized I2C engine model answers writes, and a
// LUT-walk reference predicts the write list and final status of each run.
module tb_sccb_cfg_seq;
  localparam int START = 2;
  localparam int LAST  = 60;
  localparam int POR   = 16;
  localparam int DLY   = 40;
  localparam int MAXR  = 3;

  logic        iCLK = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [7:0]  LUT_INDEX;
  logic [15:0] LUT_DATA;
  logic [7:0]  Slave_Addr = 8'h42;
  logic        wr_req;
  logic [7:0]  wr_addr, wr_reg, wr_data;
  logic        wr_busy, wr_done, wr_nack;
  logic        cfg_done, cfg_err;
  logic [7:0]  err_index;

  logic        eng_busy = 1'b0, eng_done = 1'b0, eng_nack = 1'b0;
  logic        busy_hold = 1'b0, spur_done = 1'b0;
  logic [15:0] lut [256];
  int          nack_plan [256];

  int checks = 0;
  int failures = 0;

  sccb_cfg_seq #(
    .START_INDEX(START), .LAST_INDEX(LAST), .POR_CYCLES(POR),
    .DELAY_CYCLES(DLY), .MAX_RETRY(MAXR)
  ) dut (
    .iCLK(iCLK), .rst(rst), .cfg_start(cfg_start),
    .LUT_INDEX(LUT_INDEX), .LUT_DATA(LUT_DATA), .Slave_Addr(Slave_Addr),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_reg(wr_reg), .wr_data(wr_data),
    .wr_busy(wr_busy), .wr_done(wr_done), .wr_nack(wr_nack),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .err_index(err_index)
  );

  always #5 iCLK = ~iCLK;

  assign LUT_DATA = lut[LUT_INDEX];
  assign wr_busy  = eng_busy | busy_hold;
  assign wr_done  = eng_done | spur_done;
  assign wr_nack  = eng_nack;

  // Engine: random latency, NACKs the first nack_plan[idx] attempts of an entry,
  // drives random noise on wr_nack when not completing.
  int         lat = 0, att = 0, last_idx = -1;
  logic [7:0] eng_idx = 8'h00;
  always @(negedge iCLK) begin
    eng_done <= 1'b0;
    eng_nack <= 1'($urandom_range(0, 1));
    if (rst) begin
      eng_busy <= 1'b0;
      lat      <= 0;
      att      <= 0;
      last_idx <= -1;
    end else if (wr_req && !eng_busy) begin
      eng_busy <= 1'b1;
      lat      <= $urandom_range(0, 4);
      eng_idx  <= LUT_INDEX;
      att      <= (int'(LUT_INDEX) == last_idx) ? att + 1 : 0;
      last_idx <= int'(LUT_INDEX);
    end else if (eng_busy) begin
      if (lat == 0) begin
        eng_done <= 1'b1;
        eng_nack <= (att < nack_plan[eng_idx]);
        eng_busy <= 1'b0;
      end else begin
        lat <= lat - 1;
      end
    end else if (cfg_done || cfg_err) begin
      last_idx <= -1;
    end
  end

  // Monitor: records every request, flags overlapping requests and byte changes
  logic [23:0] got_q [$];
  int          req_total = 0, done_total = 0, proto_err = 0;
  logic        outst = 1'b0;
  logic [23:0] held = '0;
  always @(negedge iCLK) begin
    if (rst) begin
      outst <= 1'b0;
    end else if (wr_req) begin
      got_q.push_back({wr_addr, wr_reg, wr_data});
      req_total <= req_total + 1;
      if (outst) proto_err <= proto_err + 1;
      outst <= 1'b1;
      held  <= {wr_addr, wr_reg, wr_data};
    end else if (outst) begin
      if ({wr_addr, wr_reg, wr_data} != held) proto_err <= proto_err + 1;
      if (eng_done) begin
        outst      <= 1'b0;
        done_total <= done_total + 1;
      end
    end
  end

  // Reference: walk the LUT by the sequencing rules, listing the writes expected
  logic [23:0] exp_q [$];
  bit          exp_done;
  int          exp_final;
  logic [7:0]  exp_err_idx;

  task automatic build_model();
    int idx, n;
    exp_q.delete();
    idx = START;
    exp_done = 1'b0;
    exp_err_idx = 8'h00;
    forever begin
      if (lut[idx] == 16'hFFFF) begin
        exp_done = 1'b1;
        break;
      end
      if (lut[idx] != 16'hFFF0) begin
        n = (nack_plan[idx] > MAXR) ? MAXR + 1 : nack_plan[idx] + 1;
        repeat (n) exp_q.push_back({Slave_Addr, lut[idx]});
        if (nack_plan[idx] > MAXR) begin
          exp_err_idx = 8'(idx);
          break;
        end
      end
      if (idx == LAST || idx == 255) begin
        exp_done = 1'b1;
        break;
      end
      idx++;
    end
    exp_final = idx;
  endtask

  function automatic int q_diff(int base);
    int d = 0;
    if (got_q.size() - base != exp_q.size()) return 1000;
    foreach (exp_q[i]) if (got_q[base + i] !== exp_q[i]) d++;
    return d;
  endfunction

  function automatic logic [15:0] rand_entry();
    logic [15:0] v = 16'($urandom);
    if (v[15:4] == 12'hFFF) v[15:8] = 8'h3c;
    return v;
  endfunction

  task automatic clear_tables();
    for (int i = 0; i < 256; i++) begin
      lut[i] = 16'hFFFF;
      nack_plan[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge iCLK); #2 rst = 1'b1;
    @(negedge iCLK);
    @(posedge iCLK); #2 rst = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge iCLK);
      if (cfg_done || cfg_err) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_req(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge iCLK);
      if (wr_req) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge iCLK); cfg_start = 1'b1;
    @(negedge iCLK); cfg_start = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    bit ok;
    clear_tables();
    lut[2] = 16'h1214; lut[3] = 16'h40d0;
    repeat (2) @(negedge iCLK);
    checks++; if (LUT_INDEX !== 8'd2) begin failures++; $display("FAIL reset_lut_index got=%0h exp=2", LUT_INDEX); end
    checks++; if (wr_req !== 1'b0) begin failures++; $display("FAIL reset_wr_req got=%b exp=0", wr_req); end
    checks++; if ({wr_addr, wr_reg, wr_data} !== 24'h0) begin failures++; $display("FAIL reset_bytes got=%h exp=0", {wr_addr, wr_reg, wr_data}); end
    checks++; if ({cfg_done, cfg_err} !== 2'b00) begin failures++; $display("FAIL reset_status got=%b exp=00", {cfg_done, cfg_err}); end
    checks++; if (err_index !== 8'h00) begin failures++; $display("FAIL reset_err_index got=%0h exp=0", err_index); end
    @(posedge iCLK); #2 rst = 1'b0;
    wait_req(200, n);
    checks++; if (n !== POR + 3) begin failures++; $display("FAIL por_latency got=%0d exp=%0d", n, POR + 3); end
    wait_end(ok);
    checks++; if (!ok) begin failures++; $display("FAIL reset_run_timeout got=0 exp=1"); end
  endtask

  task automatic test_normal_ack();
    int base;
    bit ok;
    clear_tables();
    Slave_Addr = 8'h42;
    lut[2] = 16'h1214; lut[3] = 16'h40d0; lut[4] = 16'hFFFF;
    build_model();
    base = got_q.size();
    do_reset();
    wait_end(ok);
    checks++; if (!ok) begin failures++; $display("FAIL normal_timeout got=0 exp=1"); end
    checks++; if (got_q.size() - base !== 2) begin failures++; $display("FAIL normal_req_count got=%0d exp=2", got_q.size() - base); end
    else begin
      checks++; if (got_q[base] !== 24'h421214) begin failures++; $display("FAIL normal_first got=%h exp=421214", got_q[base]); end
      checks++; if (got_q[base + 1] !== 24'h4240d0) begin failures++; $display("FAIL normal_second got=%h exp=4240d0", got_q[base + 1]); end
    end
    checks++; if (q_diff(base) !== 0) begin failures++; $display("FAIL normal_model got=%0d diffs exp=0", q_diff(base)); end
    checks++; if ({cfg_done, cfg_err} !== 2'b10) begin failures++; $display("FAIL normal_status got=%b exp=10", {cfg_done, cfg_err}); end
    checks++; if (LUT_INDEX !== 8'd4) begin failures++; $display("FAIL normal_index got=%0d exp=4", LUT_INDEX); end
  endtask

  task automatic test_soft_reset();
    int d0, gap, base;
    bit ok;
    clear_tables();
    lut[2] = 16'h1280; lut[3] = 16'h1201; lut[4] = 16'hFFFF;
    build_model();
    base = got_q.size();
    d0 = done_total;
    do_reset();
    for (int i = 0; i < 500 && done_total == d0; i++) @(negedge iCLK);
    gap = 0;
    while (LUT_INDEX != 8'd3 && gap < 5 * DLY) begin
      @(negedge iCLK);
      gap++;
    end
    checks++; if (gap < DLY || gap > DLY + 2) begin failures++; $display("FAIL softreset_settle got=%0d exp=%0d..%0d", gap, DLY, DLY + 2); end
    wait_end(ok);
    checks++; if (!ok || cfg_done !== 1'b1) begin failures++; $display("FAIL softreset_done got=%b exp=1", cfg_done); end
    checks++; if (q_diff(base) !== 0) begin failures++; $display("FAIL softreset_model got=%0d diffs exp=0", q_diff(base)); end
    checks++; if (LUT_INDEX !== 8'd4) begin failures++; $display("FAIL softreset_index got=%0d exp=4", LUT_INDEX); end
  endtask

  task automatic test_retry_limit();
    int base, r0, n5;
    bit ok;
    clear_tables();
    Slave_Addr = 8'($urandom_range(1, 254));
    lut[2] = 16'h1111; nack_plan[2] = 2;
    lut[3] = 16'h2222; nack_plan[3] = MAXR;
    lut[4] = 16'hFFF0;
    lut[5] = 16'h3355; nack_plan[5] = 99;
    lut[6] = 16'h4466;
    build_model();
    base = got_q.size();
    do_reset();
    wait_end(ok);
    checks++; if (!ok || {cfg_done, cfg_err} !== 2'b01) begin failures++; $display("FAIL retry_status got=%b exp=01", {cfg_done, cfg_err}); end
    checks++; if (err_index !== 8'd5) begin failures++; $display("FAIL retry_err_index got=%0d exp=5", err_index); end
    n5 = 0;
    for (int i = base; i < got_q.size(); i++) if (got_q[i] == {Slave_Addr, 16'h3355}) n5++;
    checks++; if (n5 !== 4) begin failures++; $display("FAIL retry_pulses_idx5 got=%0d exp=4", n5); end
    checks++; if (got_q.size() - base !== 11) begin failures++; $display("FAIL retry_total_reqs got=%0d exp=11", got_q.size() - base); end
    checks++; if (q_diff(base) !== 0) begin failures++; $display("FAIL retry_model got=%0d diffs exp=0", q_diff(base)); end
    r0 = req_total;
    repeat (40) @(negedge iCLK);
    checks++; if (req_total !== r0) begin failures++; $display("FAIL retry_no_more_req got=%0d exp=%0d", req_total, r0); end
  endtask

  task automatic test_busy();
    int base, r0;
    bit ok;
    clear_tables();
    Slave_Addr = 8'h42;
    lut[2] = 16'h2a5c;
    build_model();
    base = got_q.size();
    busy_hold = 1'b1;
    do_reset();
    repeat (POR + 4) @(negedge iCLK);
    spur_done = 1'b1;
    @(negedge iCLK); spur_done = 1'b0;
    r0 = req_total;
    repeat (20) @(negedge iCLK);
    checks++; if (req_total !== r0 || wr_req !== 1'b0) begin failures++; $display("FAIL busy_held_req got=%0d exp=%0d", req_total, r0); end
    busy_hold = 1'b0;
    @(negedge iCLK);
    checks++; if (wr_req !== 1'b1) begin failures++; $display("FAIL busy_release_req got=%b exp=1", wr_req); end
    checks++; if ({wr_addr, wr_reg, wr_data} !== 24'h422a5c) begin failures++; $display("FAIL busy_bytes got=%h exp=422a5c", {wr_addr, wr_reg, wr_data}); end
    wait_end(ok);
    checks++; if (!ok || cfg_done !== 1'b1 || q_diff(base) !== 0) begin failures++; $display("FAIL busy_run got=%b/%0d exp=1/0", cfg_done, q_diff(base)); end
  endtask

  task automatic test_reset_mid();
    int base, n;
    bit ok, hit;
    clear_tables();
    for (int i = START; i <= LAST; i++) lut[i] = rand_entry();
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      @(negedge iCLK);
      hit = (wr_req && LUT_INDEX == 8'd50);
    end
    checks++; if (!hit) begin failures++; $display("FAIL midreset_reach50 got=0 exp=1"); end
    #2 rst = 1'b1;
    #1;
    checks++; if (LUT_INDEX !== 8'd2 || wr_req !== 1'b0) begin failures++; $display("FAIL midreset_index_req got=%0d/%b exp=2/0", LUT_INDEX, wr_req); end
    checks++; if ({wr_addr, wr_reg, wr_data} !== 24'h0 || {cfg_done, cfg_err} !== 2'b00) begin failures++; $display("FAIL midreset_bytes got=%h exp=0", {wr_addr, wr_reg, wr_data}); end
    @(negedge iCLK);
    build_model();
    base = got_q.size();
    @(posedge iCLK); #2 rst = 1'b0;
    wait_req(200, n);
    checks++; if (n !== POR + 3 || LUT_INDEX !== 8'd2) begin failures++; $display("FAIL midreset_restart got=%0d@%0d exp=%0d@2", n, LUT_INDEX, POR + 3); end
    wait_end(ok);
    checks++; if (!ok || cfg_done !== 1'b1 || LUT_INDEX !== 8'(LAST)) begin failures++; $display("FAIL midreset_end got=%b@%0d exp=1@%0d", cfg_done, LUT_INDEX, LAST); end
    checks++; if (q_diff(base) !== 0 || proto_err !== 0) begin failures++; $display("FAIL midreset_model got=%0d/%0d exp=0/0", q_diff(base), proto_err); end
  endtask

  task automatic test_restart();
    int base, n;
    bit ok;
    build_model();
    base = got_q.size();
    @(negedge iCLK); cfg_start = 1'b1;
    @(negedge iCLK); cfg_start = 1'b0;
    checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL restart_done_clear got=%b exp=0", cfg_done); end
    wait_req(50, n);
    checks++; if (n !== 2 || LUT_INDEX !== 8'd2) begin failures++; $display("FAIL restart_no_por got=%0d@%0d exp=2@2", n, LUT_INDEX); end
    repeat (30) @(negedge iCLK);
    pulse_start();
    wait_end(ok);
    checks++; if (!ok || cfg_done !== 1'b1 || LUT_INDEX !== 8'(LAST)) begin failures++; $display("FAIL restart_end got=%b@%0d exp=1@%0d", cfg_done, LUT_INDEX, LAST); end
    checks++; if (q_diff(base) !== 0) begin failures++; $display("FAIL restart_model got=%0d diffs exp=0", q_diff(base)); end
  endtask

  task automatic test_random();
    int base, len;
    bit ok;
    for (int it = 0; it < 6; it++) begin
      clear_tables();
      Slave_Addr = 8'($urandom);
      len = $urandom_range(1, LAST - START + 3);
      for (int i = START; i < START + len && i < 256; i++) begin
        lut[i] = ($urandom_range(0, 7) == 0) ? 16'hFFF0 : rand_entry();
        case ($urandom_range(0, 11))
          0:       nack_plan[i] = MAXR + 1;
          1, 2, 3: nack_plan[i] = $urandom_range(1, MAXR);
          default: nack_plan[i] = 0;
        endcase
      end
      build_model();
      base = got_q.size();
      if (it % 2 == 1) do_reset();
      else pulse_start();
      wait_end(ok);
      checks++; if (!ok || cfg_done !== exp_done || cfg_err !== !exp_done) begin failures++; $display("FAIL random%0d_status got=%b%b exp=%b%b", it, cfg_done, cfg_err, exp_done, !exp_done); end
      checks++; if (LUT_INDEX !== 8'(exp_final)) begin failures++; $display("FAIL random%0d_index got=%0d exp=%0d", it, LUT_INDEX, exp_final); end
      checks++; if (!exp_done && err_index !== exp_err_idx) begin failures++; $display("FAIL random%0d_err_index got=%0d exp=%0d", it, err_index, exp_err_idx); end
      checks++; if (q_diff(base) !== 0) begin failures++; $display("FAIL random%0d_model got=%0d diffs exp=0", it, q_diff(base)); end
    end
  endtask

  initial begin
    test_reset();
    test_normal_ack();
    test_soft_reset();
    test_retry_limit();
    test_busy();
    test_reset_mid();
    test_restart();
    test_random();
    repeat (5) @(negedge iCLK);
    checks++; if (proto_err !== 0) begin failures++; $display("FAIL protocol_overlap_or_bytes got=%0d exp=0", proto_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
